alu_instr_sequencer: RTL and testbench

//  Moore FSM control unit that sequences fetch/execute T-states around the ALU datapath.

---
 rtl/alu_instr_sequencer.sv | 168 ++++++++++++++++
 tb/tb_alu_instr_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_instr_sequencer.sv
// rtl/alu_instr_sequencer.sv - Moore control FSM sequencing fetch/execute T-states around the ALU datapath
module alu_instr_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic        pc_out,
  output logic        mar_in,
  output logic        inc_pc,
  output logic        pc_in,
  output logic        read,
  output logic        mdr_in,
  output logic        mdr_out,
  output logic        ir_in,
  output logic        y_in,
  output logic        z_in,
  output logic        zlow_out,
  output logic        zhigh_out,
  output logic        lo_in,
  output logic        hi_in,
  output logic        sel_ra,
  output logic        sel_rb,
  output logic        sel_rc,
  output logic        r_out,
  output logic        r_in,
  output logic        c_out,
  output logic [4:0]  alu_op,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic        mem_fault,
  output logic        halted
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;
  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  state_t     state, state_next;
  logic [7:0] wait_cnt;
  logic [4:0] opcode;
  logic       is_reg, is_imm, is_muldiv, is_unary, is_alu;
  logic       t1_first, t1_timeout;
  logic       unused_ir;

  assign opcode    = ir[31:27];
  assign unused_ir = ^ir[26:0];

  // Opcode classes: two-register ops, immediates, HI/LO producers, single-operand ops.
  assign is_reg    = (opcode >= 5'b00011) && (opcode <= 5'b01011);
  assign is_imm    = (opcode >= 5'b01100) && (opcode <= 5'b01110);
  assign is_muldiv = (opcode == 5'b01111) || (opcode == 5'b10000);
  assign is_unary  = (opcode == 5'b10001) || (opcode == 5'b10010);
  assign is_alu    = is_reg || is_imm || is_muldiv || is_unary;

  assign t1_first   = (state == S_T1) && (wait_cnt == 8'd0);
  assign t1_timeout = (state == S_T1) && (wait_cnt == TIMEOUT_CNT);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state    <= S_IDLE;
      wait_cnt <= 8'd0;
    end else begin
      state <= state_next;
      if ((state == S_T1) && (state_next == S_T1))
        wait_cnt <= wait_cnt + 8'd1;
      else
        wait_cnt <= 8'd0;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (run) state_next = S_T0;
      S_T0:   state_next = S_T1;
      S_T1: begin
        if (t1_timeout)     state_next = S_IDLE;
        else if (mem_ready) state_next = S_T2;
      end
      S_T2: state_next = S_T3;
      S_T3: begin
        if (opcode == OP_NOP)       state_next = run ? S_T0 : S_IDLE;
        else if (opcode == OP_HALT) state_next = S_HALT;
        else if (is_alu)            state_next = S_T4;
        else                        state_next = S_IDLE;
      end
      S_T4: state_next = S_T5;
      S_T5: begin
        if (is_muldiv) state_next = S_T6;
        else           state_next = run ? S_T0 : S_IDLE;
      end
      S_T6:   state_next = run ? S_T0 : S_IDLE;
      S_HALT: state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    pc_out = 1'b0; mar_in = 1'b0; inc_pc = 1'b0; pc_in = 1'b0;
    read = 1'b0; mdr_in = 1'b0; mdr_out = 1'b0; ir_in = 1'b0;
    y_in = 1'b0; z_in = 1'b0; zlow_out = 1'b0; zhigh_out = 1'b0;
    lo_in = 1'b0; hi_in = 1'b0; sel_ra = 1'b0; sel_rb = 1'b0;
    sel_rc = 1'b0; r_out = 1'b0; r_in = 1'b0; c_out = 1'b0;
    alu_op = OP_ADD; done = 1'b0; illegal = 1'b0; mem_fault = 1'b0;
    busy   = (state != S_IDLE) && (state != S_HALT);
    halted = (state == S_HALT);
    case (state)
      S_T0: begin
        pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1;
      end
      S_T1: begin
        // The aborting cycle drops the read so nothing is latched into MDR.
        if (t1_timeout) begin
          mem_fault = 1'b1;
        end else begin
          zlow_out = 1'b1; read = 1'b1; mdr_in = 1'b1;
          pc_in    = t1_first;
        end
      end
      S_T2: begin
        mdr_out = 1'b1; ir_in = 1'b1;
      end
      S_T3: begin
        if (opcode == OP_NOP) begin
          done = 1'b1;
        end else if (is_alu) begin
          r_out = 1'b1; y_in = 1'b1;
          sel_ra = is_muldiv;
          sel_rb = !is_muldiv;
        end else if (opcode != OP_HALT) begin
          illegal = 1'b1;
        end
      end
      S_T4: begin
        alu_op = opcode; z_in = 1'b1;
        if (is_imm) begin
          c_out = 1'b1;
        end else begin
          r_out  = 1'b1;
          sel_rc = is_reg;
          sel_rb = !is_reg;
        end
      end
      S_T5: begin
        zlow_out = 1'b1;
        if (is_muldiv) begin
          lo_in = 1'b1;
        end else begin
          sel_ra = 1'b1; r_in = 1'b1; done = 1'b1;
        end
      end
      S_T6: begin
        zhigh_out = 1'b1; hi_in = 1'b1; done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// tb/tb_alu_instr_sequencer.sv - directed-vector bench for alu_instr_sequencer
module tb_alu_instr_sequencer;

  logic        clk = 1'b0;
  logic        clear, run, mem_ready;
  logic [31:0] ir;
  logic pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in;
  logic y_in, z_in, zlow_out, zhigh_out, lo_in, hi_in;
  logic sel_ra, sel_rb, sel_rc, r_out, r_in, c_out;
  logic [4:0] alu_op;
  logic busy, done, illegal, mem_fault, halted;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_instr_sequencer #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .clear(clear), .run(run), .ir(ir), .mem_ready(mem_ready),
    .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .pc_in(pc_in),
    .read(read), .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in),
    .y_in(y_in), .z_in(z_in), .zlow_out(zlow_out), .zhigh_out(zhigh_out),
    .lo_in(lo_in), .hi_in(hi_in), .sel_ra(sel_ra), .sel_rb(sel_rb),
    .sel_rc(sel_rc), .r_out(r_out), .r_in(r_in), .c_out(c_out),
    .alu_op(alu_op), .busy(busy), .done(done), .illegal(illegal),
    .mem_fault(mem_fault), .halted(halted)
  );

  logic [22:0] strobes;
  assign strobes = {pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in,
                    y_in, z_in, zlow_out, zhigh_out, lo_in, hi_in,
                    sel_ra, sel_rb, sel_rc, r_out, r_in, c_out,
                    done, illegal, mem_fault};

  localparam logic [22:0] PC_OUT = 23'd1 << 22, MAR_IN = 23'd1 << 21, INC_PC = 23'd1 << 20;
  localparam logic [22:0] PC_IN = 23'd1 << 19, READ = 23'd1 << 18, MDR_IN = 23'd1 << 17;
  localparam logic [22:0] MDR_OUT = 23'd1 << 16, IR_IN = 23'd1 << 15, Y_IN = 23'd1 << 14;
  localparam logic [22:0] Z_IN = 23'd1 << 13, ZLOW = 23'd1 << 12, ZHIGH = 23'd1 << 11;
  localparam logic [22:0] LO_IN = 23'd1 << 10, HI_IN = 23'd1 << 9, SEL_RA = 23'd1 << 8;
  localparam logic [22:0] SEL_RB = 23'd1 << 7, SEL_RC = 23'd1 << 6, R_OUT = 23'd1 << 5;
  localparam logic [22:0] R_IN = 23'd1 << 4, C_OUT = 23'd1 << 3, DONE = 23'd1 << 2;
  localparam logic [22:0] ILLEGAL = 23'd1 << 1, MEM_FAULT = 23'd1;

  localparam logic [22:0] E_T0     = PC_OUT | MAR_IN | INC_PC | Z_IN;
  localparam logic [22:0] E_T1F    = ZLOW | PC_IN | READ | MDR_IN;
  localparam logic [22:0] E_T1W    = ZLOW | READ | MDR_IN;
  localparam logic [22:0] E_T2     = MDR_OUT | IR_IN;
  localparam logic [22:0] E_T3R    = SEL_RB | R_OUT | Y_IN;
  localparam logic [22:0] E_T3M    = SEL_RA | R_OUT | Y_IN;
  localparam logic [22:0] E_T4R    = Z_IN | SEL_RC | R_OUT;
  localparam logic [22:0] E_T4I    = Z_IN | C_OUT;
  localparam logic [22:0] E_T4M    = Z_IN | SEL_RB | R_OUT;
  localparam logic [22:0] E_T5R    = ZLOW | SEL_RA | R_IN | DONE;
  localparam logic [22:0] E_T5M    = ZLOW | LO_IN;
  localparam logic [22:0] E_T6     = ZHIGH | HI_IN | DONE;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b1; run = 1'b0; mem_ready = 1'b0; ir = 32'h0;
    #3;
    vectors++;
    if (strobes !== 23'd0 || alu_op !== 5'b00011 || busy !== 1'b0 || halted !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: strobes=%h alu_op=%b busy=%b halted=%b, want 0/00011/0/0",
               strobes, alu_op, busy, halted);
    end
    tick();
    clear = 1'b0;
    tick();
  endtask

  task automatic test_add();
    logic [22:0] exp [7] = '{E_T0, E_T1F, E_T2, E_T3R, E_T4R, E_T5R, 23'd0};
    ir = 32'h19890000; mem_ready = 1'b1; run = 1'b1;
    tick();
    run = 1'b0;
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (strobes !== exp[i]) begin
        miscompares++;
        $display("FAIL add cycle %0d: strobes=%h want %h", i + 1, strobes, exp[i]);
      end
      if (i == 4) begin
        vectors++;
        if (alu_op !== 5'b00011) begin
          miscompares++;
          $display("FAIL add alu_op: got %b want 00011", alu_op);
        end
      end
      if (i < 6) tick();
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL add idle busy: got %b want 0", busy);
    end
  endtask

  task automatic test_mul_wait();
    logic [22:0] exp [11] = '{E_T0, E_T1F, E_T1W, E_T1W, E_T1W, E_T2, E_T3M, E_T4M,
                              E_T5M, E_T6, 23'd0};
    ir = 32'h78880000; mem_ready = 1'b0; run = 1'b1;
    tick();
    run = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (i == 4) mem_ready = 1'b1;
      vectors++;
      if (strobes !== exp[i]) begin
        miscompares++;
        $display("FAIL mul cycle %0d: strobes=%h want %h", i + 1, strobes, exp[i]);
      end
      if (i == 7) begin
        vectors++;
        if (alu_op !== 5'b01111) begin
          miscompares++;
          $display("FAIL mul alu_op: got %b want 01111", alu_op);
        end
      end
      if (i < 10) tick();
    end
  endtask

  task automatic test_timeout();
    logic [22:0] e;
    ir = 32'h19890000; mem_ready = 1'b0; run = 1'b1;
    tick();
    run = 1'b0;
    for (int i = 0; i < 18; i++) begin
      e = (i == 0) ? E_T0 : (i == 1) ? E_T1F : (i < 16) ? E_T1W : (i == 16) ? MEM_FAULT : 23'd0;
      vectors++;
      if (strobes !== e) begin
        miscompares++;
        $display("FAIL timeout cycle %0d: strobes=%h want %h", i + 1, strobes, e);
      end
      if (i < 17) tick();
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout idle busy: got %b want 0", busy);
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_halt();
    ir = 32'hD8000000; mem_ready = 1'b1; run = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (halted !== 1'b1 || busy !== 1'b0 || strobes !== 23'd0) begin
        miscompares++;
        $display("FAIL halt hold %0d: halted=%b busy=%b strobes=%h want 1/0/0",
                 i, halted, busy, strobes);
      end
      run = ~run;
      tick();
    end
    #2 clear = 1'b1;
    #1;
    vectors++;
    if (halted !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL halt clear: halted=%b busy=%b want 0/0", halted, busy);
    end
    run = 1'b0;
    tick();
    clear = 1'b0;
    tick();
  endtask

  task automatic test_illegal();
    logic [22:0] exp [5] = '{E_T0, E_T1F, E_T2, ILLEGAL, 23'd0};
    ir = 32'h98000000; mem_ready = 1'b1; run = 1'b1;
    tick();
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (strobes !== exp[i]) begin
        miscompares++;
        $display("FAIL illegal cycle %0d: strobes=%h want %h", i + 1, strobes, exp[i]);
      end
      if (i < 4) tick();
    end
  endtask

  task automatic test_clear_mid();
    ir = 32'h19890000; mem_ready = 1'b1; run = 1'b1;
    tick();
    run = 1'b0;
    tick(); tick(); tick(); tick();
    vectors++;
    if (strobes !== E_T4R) begin
      miscompares++;
      $display("FAIL clear_mid pre: strobes=%h want %h", strobes, E_T4R);
    end
    #2 clear = 1'b1;
    #1;
    vectors++;
    if (strobes !== 23'd0 || alu_op !== 5'b00011 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_mid: strobes=%h alu_op=%b busy=%b want 0/00011/0",
               strobes, alu_op, busy);
    end
    tick();
    clear = 1'b0;
    tick();
    vectors++;
    if (busy !== 1'b0 || strobes !== 23'd0) begin
      miscompares++;
      $display("FAIL clear_mid idle: busy=%b strobes=%h want 0/0", busy, strobes);
    end
  endtask

  task automatic test_back_to_back();
    logic [22:0] exp [13] = '{E_T0, E_T1F, E_T2, E_T3R, E_T4R, E_T5R,
                              E_T0, E_T1F, E_T2, E_T3R, E_T4I, E_T5R, 23'd0};
    ir = 32'h19890000; mem_ready = 1'b1; run = 1'b1;
    tick();
    for (int i = 0; i < 13; i++) begin
      if (i == 6) ir = 32'h60880005;
      if (i == 11) run = 1'b0;
      vectors++;
      if (strobes !== exp[i]) begin
        miscompares++;
        $display("FAIL b2b cycle %0d: strobes=%h want %h", i + 1, strobes, exp[i]);
      end
      if (i == 10) begin
        vectors++;
        if (alu_op !== 5'b01100) begin
          miscompares++;
          $display("FAIL b2b addi alu_op: got %b want 01100", alu_op);
        end
      end
      if (i < 12) tick();
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b idle busy: got %b want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul_wait();
    test_timeout();
    test_halt();
    test_illegal();
    test_clear_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
